dadda_mul_arb: RTL and testbench
================================

DADDA_MUL_ARB -- requirements
Module: dadda_mul_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one 8x8 Dadda multiplier (range 2..8).
REQ-002 SHALL have parameter WAIT_CYC, default 2, settle cycles allowed for the combinational multiplier (range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester operation request.
REQ-006 SHALL have port req_a, input, 8*NREQ, multiplicand; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_b, input, 8*NREQ, multiplier; same packing as req_a.
REQ-008 SHALL have port req_ready, output, NREQ, one-hot accept strobe.
REQ-009 SHALL have port mul_a, output, 8, registered operand to the external dadda instance.
REQ-010 SHALL have port mul_b, output, 8, registered operand to the external dadda instance.
REQ-011 SHALL have port mul_result, input, 16, product from the external dadda instance.
REQ-012 SHALL have port rsp_valid, output, 1, response valid.
REQ-013 SHALL have port rsp_id, output, 3, index of the requester owning the response.
REQ-014 SHALL have port rsp_data, output, 16, registered product.
REQ-015 SHALL have port rsp_ready, input, 1, response consumer ready.

Function
REQ-016 SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-017 In IDLE with any req_valid set, the block SHALL assert req_ready for exactly one winner, combinationally, in that cycle.
REQ-018 In IDLE with no req_valid set, req_ready SHALL be 0.
REQ-019 At the accept edge the block SHALL load mul_a/mul_b from the winner, record the winner in rsp_id, load the counter with WAIT_CYC-1 and enter WAIT.
REQ-020 In WAIT, each edge SHALL decrement the counter while it is nonzero.
REQ-021 In WAIT, when the counter is 0, the edge SHALL capture mul_result into rsp_data and enter RESP, so rsp_valid rises exactly WAIT_CYC edges after the accept edge.
REQ-022 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_id SHALL hold stable until rsp_valid && rsp_ready; that edge SHALL return the block to IDLE.
REQ-023 req_ready SHALL be 0 in WAIT and RESP.
REQ-024 No new request SHALL be accepted on the RESP handshake edge; minimum issue interval is WAIT_CYC+2 cycles.
REQ-025 mul_a/mul_b SHALL hold their values outside the accept edge.
REQ-026 Arithmetic SHALL be unsigned 8x8 to 16 bits with no truncation; rsp_data SHALL equal mul_result as sampled.
REQ-027 A requester dropping req_valid before grant SHALL NOT be granted.
REQ-028 Widths of rsp_id above log2(NREQ) SHALL read 0.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, counter 0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0 and the round-robin pointer to 0.
REQ-030 Reset asserted during WAIT or RESP SHALL discard the in-flight operation without producing a response.

Configuration
REQ-031 With macro DADDA_MUL_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at (last granted index + 1) mod NREQ and the pointer updates only on the accept edge.
REQ-032 Without DADDA_MUL_ARB_RR_EN, arbitration SHALL be fixed priority with the lowest index winning, and no pointer register SHALL exist.

Structure
REQ-033 Package dadda_mul_arb_pkg SHALL hold the state enum (IDLE/WAIT/RESP), operand width 8, product width 16 and counter width 4.
REQ-034 The winner selection SHALL be a sub-module dadda_arb_pick with inputs req_valid and pointer and a one-hot grant output.
REQ-035 The dadda multiplier SHALL be instantiated outside this block and connected via mul_a/mul_b/mul_result.

Verification
REQ-036 A bench SHALL check: req0 a=13 b=11 with WAIT_CYC=2 -> req_ready[0] in the accept cycle; rsp_valid 2 edges later, rsp_data=0x008F, rsp_id=0.
REQ-037 A bench SHALL check: req2 a=255 b=255 -> rsp_data=0xFE01, rsp_id=2.
REQ-038 A bench SHALL check: all four valid continuously, with RR enabled -> grant order 0,1,2,3,0; without RR -> 0,0,0.
REQ-039 A bench SHALL check: rsp_ready held low for 5 cycles -> rsp_valid, rsp_data and rsp_id stable and req_ready=0 throughout; the handshake returns to IDLE.
REQ-040 A bench SHALL check: rst pulsed during WAIT -> no rsp_valid, all outputs 0; the next request completes normally.
REQ-041 A bench SHALL check: req1 a=0 b=200 -> rsp_data=0x0000.

Source files
------------

// File: rtl/dadda_mul_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package dadda_mul_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 4;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dadda_arb_pick.sv
// Winner selection: first valid requester searching upward from pointer (wrapping).
module dadda_arb_pick
  import dadda_mul_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] pointer,
  output logic [NREQ-1:0] grant
);

  logic w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req_valid[i] && (((int'(pointer) + k) % NREQ) == i)) begin
          grant[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dadda_mul_arb.sv
// Shares one external 8x8 Dadda multiplier among NREQ requesters.
// Define DADDA_MUL_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 wins).
//
//   state | meaning
//   IDLE  | waiting for a request; grant is combinational
//   WAIT  | operands applied, counting down multiplier settle cycles
//   RESP  | product held on rsp_data until the consumer takes it
module dadda_mul_arb
  import dadda_mul_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [OP_W*NREQ-1:0]   req_a,
  input  logic [OP_W*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]      mul_result,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PROD_W-1:0]      rsp_data,
  input  logic                   rsp_ready
);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [OP_W-1:0]     r_mul_a;
  logic [OP_W-1:0]     r_mul_b;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [PROD_W-1:0]   r_rsp_data;

  logic [NREQ-1:0]     w_grant;
  logic [ID_W-1:0]     w_ptr;
  logic [ID_W-1:0]     w_win_idx;
  logic [OP_W-1:0]     w_win_a;
  logic [OP_W-1:0]     w_win_b;
  logic                w_accept;

`ifdef DADDA_MUL_ARB_RR_EN
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     w_ptr_next;

  // r_ptr holds the first index to search, i.e. last winner + 1 (mod NREQ)
  assign w_ptr      = r_ptr;
  assign w_ptr_next = (w_win_idx == ID_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_next;
    end
  end
`else
  assign w_ptr = '0;
`endif

  dadda_arb_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_valid (req_valid),
    .pointer   (w_ptr),
    .grant     (w_grant)
  );

  assign w_win_idx = onehot_to_idx(8'(w_grant));
  assign w_accept  = (r_state == IDLE) && (|req_valid);

  always_comb begin
    w_win_a = '0;
    w_win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_win_a = w_win_a | req_a[OP_W*i +: OP_W];
        w_win_b = w_win_b | req_b[OP_W*i +: OP_W];
      end
    end
  end

  assign req_ready = (r_state == IDLE) ? w_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mul_a  <= w_win_a;
            r_mul_b  <= w_win_b;
            r_rsp_id <= w_win_idx;
            r_cnt    <= CNT_W'(WAIT_CYC - 1);
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_data  <= mul_result;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          // Returning to IDLE here means no grant can coincide with the handshake edge
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_dadda_mul_arb.sv
// Directed bench for dadda_mul_arb; expected responses go to a queue that a negedge monitor drains.
module tb_dadda_mul_arb;

  localparam int NREQ     = 4;
  localparam int WAIT_CYC = 2;

`ifdef DADDA_MUL_ARB_RR_EN
  localparam int NG = 5;
  localparam int EXP_ORDER [5] = '{0, 1, 2, 3, 0};
`else
  localparam int NG = 3;
  localparam int EXP_ORDER [3] = '{0, 0, 0};
`endif
  localparam logic [15:0] PROD [4] = '{16'd10, 16'd20, 16'd30, 16'd40};

  logic             clk;
  logic             rst;
  logic [NREQ-1:0]  req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]  req_ready;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic [15:0]      mul_result;
  logic             rsp_valid;
  logic [2:0]       rsp_id;
  logic [15:0]      rsp_data;
  logic             rsp_ready;

  int errors = 0;
  int checks = 0;
  logic [18:0] sb_q [$];

  dadda_mul_arb #(
    .NREQ     (NREQ),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  // stand-in for the external combinational multiplier
  assign mul_result = 16'(mul_a) * 16'(mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
      end else begin
        logic [18:0] e;
        e = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[18:16]));
        chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
      end
    end
  end

  // Call just after a posedge with the DUT idle and rsp_ready high
  task automatic do_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_d);
    req_valid[idx] = 1'b1;
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(1 << idx));
    sb_q.push_back({3'(idx), exp_d});
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    for (int k = 0; k < WAIT_CYC; k++) begin
      @(negedge clk);
      chk("wait_no_valid", 32'(rsp_valid), 32'd0);
      chk("wait_no_ready", 32'(req_ready), 32'd0);
      if (k == 0) begin
        chk("mul_a", 32'(mul_a), 32'(a));
        chk("mul_b", 32'(mul_b), 32'(b));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc;
    int cyc;
    int seen;
    bit found;

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'(req_ready), 32'd0);
    @(posedge clk); #1;

    do_req(0, 8'd13, 8'd11, 16'h008F);
    do_req(2, 8'd255, 8'd255, 16'hFE01);
    do_req(1, 8'd0, 8'd200, 16'h0000);

    // Contention: all requesters valid, pointer cleared first
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(i + 1);
      req_b[8*i +: 8] = 8'd10;
    end
    req_valid = '1;
    cyc = 0;
    last_cyc = 0;
    for (int g = 0; g < NG; g++) begin
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
        @(negedge clk);
        cyc++;
        if (req_ready != '0) begin
          found = 1'b1;
          chk("grant_onehot", 32'($countones(req_ready)), 32'd1);
          chk("grant_order", 32'(oh_idx(req_ready)), 32'(EXP_ORDER[g]));
          if (g > 0) chk("issue_interval", 32'(cyc - last_cyc), 32'(WAIT_CYC + 2));
          last_cyc = cyc;
          sb_q.push_back({3'(EXP_ORDER[g]), PROD[EXP_ORDER[g]]});
        end
      end
      if (!found) chk("grant_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2 * (WAIT_CYC + 2)) @(posedge clk);
    #1;

    // Back-pressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    req_valid[3] = 1'b1;
    req_a[31:24] = 8'd7;
    req_b[31:24] = 8'd9;
    @(negedge clk);
    chk("stall_grant", 32'(req_ready), 32'b1000);
    sb_q.push_back({3'd3, 16'h003F});
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    req_valid[0] = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      if (rsp_valid) found = 1'b1;
    end
    chk("stall_rsp_seen", 32'(found), 32'd1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'h003F);
      chk("stall_id", 32'(rsp_id), 32'd3);
      chk("stall_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("dropped_not_granted", 32'(req_ready), 32'd0);
    @(posedge clk); #1;

    // Reset during WAIT discards the operation
    req_valid[0] = 1'b1;
    req_a[7:0] = 8'd5;
    req_b[7:0] = 8'd6;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst_mul_a", 32'(mul_a), 32'd0);
    chk("midrst_mul_b", 32'(mul_b), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    #1 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    @(posedge clk); #1;
    do_req(1, 8'd3, 8'd4, 16'h000C);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
